// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the UART program loader.
package loader_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int COUNT_BYTES    = 2;

    typedef enum logic [2:0] {
        COUNT_LO, COUNT_HI, WORD, WRITE, CHECKSUM, DONE, ERROR
    } loader_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [31:0] max_words(input int size);
        return 32'd1 << (size - 2);
    endfunction
endpackage

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with input synchronizer, mid-bit sampling and
// false-start rejection; emits one-cycle byte_valid / framing_error pulses.
module uart_receiver
    import loader_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_value,
    output logic       byte_valid,
    output logic       framing_error
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);

    rx_state_t state_q, state_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          rx_s, fall, tick;

    // sync_q[1] is the synchronized line, sync_q[2] its previous value
    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];
    assign tick = cnt_q == CW'(CLOCKS_PER_BIT - 1);

    assign byte_value    = shift_q;
    assign byte_valid    = valid_q;
    assign framing_error = ferr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d   = '0;
                state_d = fall ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt_q == CW'(CLOCKS_PER_BIT / 2 - 1)) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == BW'(UART_DATA_BITS - 1)) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (tick) begin
                valid_d = rx_s;
                ferr_d  = ~rx_s;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a counted, XOR-checksummed program image over UART,
// writes it word by word into the instruction bank and releases the CPU on success.
module program_loader
    import loader_pkg::*;
#(
    parameter int CLOCKS_PER_BIT        = 868,
    parameter int INSTRUCTION_BANK_SIZE = 10
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             uart_rx,
    output logic [INSTRUCTION_BANK_SIZE-1:0] load_address,
    output logic                             load_write_enable,
    output logic [31:0]                      load_write_value,
    output logic                             cpu_hold,
    output logic                             load_done,
    output logic                             load_error,
    output logic [15:0]                      words_loaded
);
    loader_state_t state_q, state_d;
    logic [8*COUNT_BYTES-1:0]         count_q, count_d;
    logic [31:0]                      word_q, word_d, wval_q, wval_d;
    logic [1:0]                       idx_q, idx_d;
    logic [7:0]                       csum_q, csum_d;
    logic [15:0]                      words_q, words_d;
    logic [INSTRUCTION_BANK_SIZE-1:0] addr_q, addr_d;
    logic [7:0]                       rx_byte;
    logic                             rx_valid, rx_ferr;
    logic [15:0]                      n;

    uart_receiver #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_rx (
        .clock        (clock),
        .reset        (reset),
        .rx           (uart_rx),
        .byte_value   (rx_byte),
        .byte_valid   (rx_valid),
        .framing_error(rx_ferr)
    );

    assign n                 = {rx_byte, count_q[7:0]};
    assign load_address      = addr_q;
    assign load_write_value  = wval_q;
    assign load_write_enable = state_q == WRITE;
    assign cpu_hold          = state_q != DONE;
    assign load_done         = state_q == DONE;
    assign load_error        = state_q == ERROR;
    assign words_loaded      = words_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        words_d = words_q;
        addr_d  = addr_q;
        wval_d  = wval_q;
        if (rx_valid && state_q inside {COUNT_LO, COUNT_HI, WORD})
            csum_d = csum_q ^ rx_byte;
        unique case (state_q)
            COUNT_LO: if (rx_valid) begin
                count_d[7:0] = rx_byte;
                state_d      = COUNT_HI;
            end
            COUNT_HI: if (rx_valid) begin
                count_d = n;
                idx_d   = '0;
                state_d = (n == '0) ? CHECKSUM :
                          (32'(n) > max_words(INSTRUCTION_BANK_SIZE)) ? ERROR : WORD;
            end
            WORD: if (rx_valid) begin
                word_d[8*idx_q +: 8] = rx_byte;
                idx_d = idx_q + 1'b1;
                // Latch address and word now so they hold steady after the strobe
                if (idx_q == 2'd3) begin
                    addr_d  = INSTRUCTION_BANK_SIZE'({words_q, 2'b00});
                    wval_d  = {rx_byte, word_q[23:0]};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_q + 16'd1 == count_q) ? CHECKSUM : WORD;
            end
            CHECKSUM: if (rx_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
            default: ;
        endcase
        if (rx_ferr && state_q != DONE && state_q != ERROR)
            state_d = ERROR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COUNT_LO;
            count_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            words_q <= '0;
            addr_q  <= '0;
            wval_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wval_q  <= wval_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scenario tasks drive UART images; a write monitor pops a scoreboard.
module tb_program_loader;
    localparam int CPB = 4;

    logic        clock, reset, uart_rx;
    logic [9:0]  load_address;
    logic        load_write_enable;
    logic [31:0] load_write_value;
    logic        cpu_hold, load_done, load_error;
    logic [15:0] words_loaded;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] v;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] img [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};

    program_loader #(.CLOCKS_PER_BIT(CPB), .INSTRUCTION_BANK_SIZE(10)) dut (
        .clock            (clock),
        .reset            (reset),
        .uart_rx          (uart_rx),
        .load_address     (load_address),
        .load_write_enable(load_write_enable),
        .load_write_value (load_write_value),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error),
        .words_loaded     (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every strobe cycle must match the next expected write; a stretched strobe pops twice
    always @(negedge clock) begin
        if (load_write_enable === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h val=%h", load_address, load_write_value);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (load_address !== e.a || load_write_value !== e.v)
                    $display("FAIL write addr=%h val=%h want addr=%h val=%h",
                             load_address, load_write_value, e.a, e.v);
                else passed++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    task automatic send_img(input int cnt, input logic [7:0] cs);
        for (int i = 0; i < cnt; i++) send_byte(i == 10 ? cs : img[i]);
    endtask

    task automatic push_img_writes();
        exp_q.push_back('{10'h000, 32'h0000_0013});
        exp_q.push_back('{10'h004, 32'hDEAD_BEEF});
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic [15:0] words);
        repeat (4) @(negedge clock);
        total++;
        if (load_done !== done) $display("FAIL %s_done got=%b want=%b", tag, load_done, done);
        else passed++;
        total++;
        if (load_error !== err) $display("FAIL %s_error got=%b want=%b", tag, load_error, err);
        else passed++;
        total++;
        if (cpu_hold !== hold) $display("FAIL %s_hold got=%b want=%b", tag, cpu_hold, hold);
        else passed++;
        total++;
        if (words_loaded !== words) $display("FAIL %s_words got=%0d want=%0d", tag, words_loaded, words);
        else passed++;
        total++;
        if (exp_q.size() != 0) $display("FAIL %s_pending got=%0d want=0", tag, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (load_write_enable !== 1'b0) $display("FAIL rst_we got=%b want=0", load_write_enable);
        else passed++;
        total++;
        if (load_address !== 10'h0) $display("FAIL rst_addr got=%h want=0", load_address);
        else passed++;
        total++;
        if (load_write_value !== 32'h0) $display("FAIL rst_val got=%h want=0", load_write_value);
        else passed++;
        check_status("rst", 1'b0, 1'b0, 1'b1, 16'd0);
        repeat (200) @(negedge clock);
        check_status("idle", 1'b0, 1'b0, 1'b1, 16'd0);
    endtask

    task automatic test_load_ok();
        apply_reset();
        push_img_writes();
        send_img(10, 8'h00);
        check_status("pre_cs", 1'b0, 1'b0, 1'b1, 16'd2);
        send_byte(8'h33);
        check_status("ok", 1'b1, 1'b0, 1'b0, 16'd2);
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        push_img_writes();
        send_img(11, 8'h34);
        check_status("badcs", 1'b0, 1'b1, 1'b1, 16'd2);
        send_byte(8'h55);
        check_status("badcs_after", 1'b0, 1'b1, 1'b1, 16'd2);
    endtask

    task automatic test_count_bounds();
        apply_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check_status("zero", 1'b1, 1'b0, 1'b0, 16'd0);
        apply_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check_status("ovf", 1'b0, 1'b1, 1'b1, 16'd0);
    endtask

    task automatic test_glitch_and_framing();
        apply_reset();
        @(negedge clock);
        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clock);
        check_status("glitch", 1'b0, 1'b0, 1'b1, 16'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check_status("glitch_then_zero", 1'b1, 1'b0, 1'b0, 16'd0);
        apply_reset();
        send_byte(8'h02, 1'b0);
        check_status("frame", 1'b0, 1'b1, 1'b1, 16'd0);
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        send_img(5, 8'h00);
        apply_reset();
        check_status("midrst", 1'b0, 1'b0, 1'b1, 16'd0);
        push_img_writes();
        send_img(11, 8'h33);
        check_status("reload", 1'b1, 1'b0, 1'b0, 16'd2);
    endtask

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_count_bounds();
        test_glitch_and_framing();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the instruction bank.
- Receives a program image over a UART serial line, assembles bytes into 32-bit little-endian words and writes them sequentially into the instruction bank.
- Holds the CPU in reset until the image is fully loaded and the checksum has been verified.

Parameters:
CLOCKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4
INSTRUCTION_BANK_SIZE, 10, instruction bank byte-address width; capacity = 2^(INSTRUCTION_BANK_SIZE-2) words

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high; restarts the loader
uart_rx  input  1  asynchronous serial input, idles high, 8N1, LSB first
load_address  output  INSTRUCTION_BANK_SIZE  byte address of the word being written, always a multiple of 4
load_write_enable  output  1  one-cycle write strobe to the instruction bank
load_write_value  output  32  word to write
cpu_hold  output  1  high keeps the CPU in reset; low only in DONE
load_done  output  1  sticky: image loaded and checksum OK
load_error  output  1  sticky: count overflow, framing error or checksum mismatch
words_loaded  output  16  number of words written so far

Behaviour:
- Reset values: cpu_hold=1, load_write_enable=0, load_done=0, load_error=0, load_address=0, load_write_value=0, words_loaded=0. FSM=COUNT_LO, checksum=0, receiver idle.
- Reset mid-load: aborts and restarts at COUNT_LO. Words already written are not cleared.
- Receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. At CLOCKS_PER_BIT/2 the start bit is re-sampled; if it is high, this is a false start and the receiver returns to idle with no byte.
  - 8 data bits are sampled every CLOCKS_PER_BIT, LSB first.
  - At the stop-bit sample, stop=1 gives a one-cycle byte_valid pulse. stop=0 gives a one-cycle framing_error pulse, and the byte is discarded.
  - After the stop-bit sample the receiver returns to idle and waits for the next falling edge.
- Stream format: count_lo, count_hi (N words, 16-bit LE), then N×4 word bytes (each word LE), then 1 checksum byte.
  - The checksum byte must equal the XOR of all preceding bytes, including the count bytes.
- Loader FSM states: COUNT_LO, COUNT_HI, WORD, WRITE, CHECKSUM, DONE, ERROR.
  - COUNT_LO: byte is the count low byte → COUNT_HI.
  - COUNT_HI:
    - N > 2^(INSTRUCTION_BANK_SIZE-2) → ERROR.
    - N = 0 → CHECKSUM.
    - Otherwise → WORD.
  - WORD: a 2-bit byte index fills bits [8i+7:8i] of the word register. The 4th byte → WRITE.
  - WRITE (exactly 1 cycle):
    - load_write_enable=1, load_address=4×words_loaded, load_write_value=assembled word.
    - Next cycle: words_loaded increments.
    - Next state: CHECKSUM if words_loaded+1 == N, else WORD.
    - WRITE lasts 1 cycle and byte period is ≥ 40 cycles, so a byte can never arrive during WRITE.
  - CHECKSUM: match → DONE, mismatch → ERROR.
  - DONE: cpu_hold=0, load_done=1. Terminal until reset; further bytes are ignored.
  - ERROR: load_error=1, cpu_hold=1. Terminal until reset; further bytes are ignored.
- A framing_error in any non-terminal state → ERROR.
- The running checksum XORs each byte on its byte_valid pulse, except the checksum byte itself.
- Output timing:
  - load_done/load_error assert and cpu_hold drops on the cycle after the deciding byte_valid pulse.
  - load_address and load_write_value hold their last values outside WRITE.

Decomposition:
- Package loader_pkg:
  - FSM state enum loader_state_t.
  - UART_DATA_BITS=8.
  - COUNT_BYTES=2.
  - Function max_words(size).
- Sub-module uart_receiver (CLOCKS_PER_BIT):
  - Ports: clock, reset, rx → byte_value[7:0], byte_valid, framing_error.
  - Contains the synchronizer, bit timer and bit counter.

Test Plan:
All tests use CLOCKS_PER_BIT=4 and INSTRUCTION_BANK_SIZE=10.
- Hold reset 3 cycles, idle rx → all outputs at reset values; no writes for 200 cycles.
- Send 02 00 13 00 00 00 EF BE AD DE 33 → writes (addr 0x000, 0x00000013) then (0x004, 0xDEADBEEF), one cycle each; words_loaded=2; load_done=1; cpu_hold=0.
- Same stream with checksum 34 → both writes occur; load_error=1, cpu_hold=1, load_done=0; a further byte 55 has no effect.
- Send 00 00 00 → load_done=1, no write strobes. Send 01 01 (257 > 256) → load_error=1 immediately after the second byte, no writes.
- rx low pulse of 1 cycle → no byte, FSM stays COUNT_LO. Byte with stop bit 0 → load_error=1.
- Reset asserted after 5 bytes of the test-2 stream, then the full test-2 stream sent → identical result to test 2.
